// File: rtl/rtc_bus_scheduler_pkg.sv
// Shared types and constants for the RTC bus scheduler: FSM states, the
// logical-index to RTC-address map and strobe levels.
package rtc_bus_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ADDR_LOW = 3'd1;
    localparam state_t ST_ADDR_GAP = 3'd2;
    localparam state_t ST_DATA_LOW = 3'd3;
    localparam state_t ST_DATA_GAP = 3'd4;

    localparam logic [3:0] N_REFRESH  = 4'd9;
    localparam logic       STROBE_ON  = 1'b0;
    localparam logic       STROBE_OFF = 1'b1;

    typedef struct packed {
        logic       legal;
        logic [7:0] addr;
    } reg_map_t;

    function automatic reg_map_t map_index(input logic [3:0] idx);
        reg_map_t m;
        m.legal = 1'b1;
        case (idx)
            4'd0:    m.addr = 8'h21;
            4'd1:    m.addr = 8'h22;
            4'd2:    m.addr = 8'h23;
            4'd3:    m.addr = 8'h26;
            4'd4:    m.addr = 8'h25;
            4'd5:    m.addr = 8'h24;
            4'd6:    m.addr = 8'h41;
            4'd7:    m.addr = 8'h42;
            4'd8:    m.addr = 8'h43;
            4'd9:    m.addr = 8'h00;
            4'd10:   m.addr = 8'hF2;
            4'd11:   m.addr = 8'hF1;
            default: begin
                m.legal = 1'b0;
                m.addr  = 8'h00;
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rtc_bus_scheduler_if.sv
// Keyboard, display-readback and RTC pin bundle of the scheduler.
interface rtc_bus_scheduler_if;
    import rtc_bus_pkg::*;

    logic       kb_req;
    logic [3:0] kb_index;
    logic [7:0] kb_data;
    logic       kb_ack;
    logic       kb_err;
    logic       rd_valid;
    logic [3:0] rd_index;
    logic [7:0] rd_data;
    logic       rtc_cs_n;
    logic       rtc_rd_n;
    logic       rtc_wr_n;
    logic       rtc_ad_sel;
    logic [7:0] rtc_ad_out;
    logic       rtc_ad_oe;
    logic [7:0] rtc_ad_in;

    modport master (
        input  kb_req, kb_index, kb_data, rtc_ad_in,
        output kb_ack, kb_err, rd_valid, rd_index, rd_data,
               rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad_sel, rtc_ad_out, rtc_ad_oe
    );

    modport slave (
        output kb_req, kb_index, kb_data, rtc_ad_in,
        input  kb_ack, kb_err, rd_valid, rd_index, rd_data,
               rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad_sel, rtc_ad_out, rtc_ad_oe
    );
endinterface

// File: rtl/rtc_bus_scheduler_refresh_tick.sv
// Free-running modulo-PERIOD counter producing a registered one-cycle tick
// each time it wraps.
module refresh_tick #(
    parameter int unsigned PERIOD = 100000
) (
    input  logic CLK,
    input  logic RESET,
    output logic o_tick
);
    localparam int unsigned CW = $clog2(PERIOD);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Count 0..PERIOD-1 and flag the wrap.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CW'(PERIOD - 1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates the RTC multiplexed AD bus between keyboard writes and periodic
// refresh reads, and sequences the CS/RD/WR/AD-select strobes.
module rtc_bus_scheduler
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_PHASE        = 4,
    parameter int unsigned T_GAP          = 2,
    parameter int unsigned REFRESH_PERIOD = 100000
) (
    input  logic                CLK,
    input  logic                RESET,
    rtc_bus_scheduler_if.master bus
);
    localparam int unsigned   MAX_LEN    = (T_PHASE > T_GAP) ? T_PHASE : T_GAP;
    localparam int unsigned   CW         = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] PHASE_LAST = CW'(T_PHASE - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(T_GAP - 1);
    localparam logic [3:0]    LAST_IDX   = N_REFRESH - 4'd1;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_is_wr, w_is_wr_nxt;
    logic [7:0]    r_addr, w_addr_nxt;
    logic [7:0]    r_wdata, w_wdata_nxt;
    logic [3:0]    r_cur_idx, w_cur_idx_nxt;
    logic [3:0]    r_burst_idx;
    logic          r_kb_armed, r_pending, r_in_burst;
    logic          w_tick, w_kb_accept, w_kb_illegal, w_burst_start, w_read_done, w_rd_sample;
    reg_map_t      w_kb_map, w_rf_map;

    logic       w_cs_n, w_rd_n, w_wr_n, w_ad_sel, w_ad_oe, w_kb_ack, w_rd_valid;
    logic [7:0] w_ad_out;
    logic       r_cs_n, r_rd_n, r_wr_n, r_ad_sel, r_ad_oe;
    logic       r_kb_ack, r_kb_err, r_rd_valid;
    logic [7:0] r_ad_out, r_rd_data;
    logic [3:0] r_rd_index;

    refresh_tick #(.PERIOD(REFRESH_PERIOD)) u_tick (
        .CLK    (CLK),
        .RESET  (RESET),
        .o_tick (w_tick)
    );

    // Next-state logic: IDLE arbitration (kb first) and phase sequencing.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_is_wr_nxt   = r_is_wr;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_cur_idx_nxt = r_cur_idx;
        w_kb_accept   = 1'b0;
        w_kb_illegal  = 1'b0;
        w_burst_start = 1'b0;
        w_read_done   = 1'b0;
        w_kb_map      = map_index(bus.kb_index);
        w_rf_map      = map_index(r_burst_idx);
        case (r_state)
            ST_IDLE: begin
                if (bus.kb_req && r_kb_armed) begin
                    w_kb_accept = 1'b1;
                    if (w_kb_map.legal) begin
                        w_state_nxt = ST_ADDR_LOW;
                        w_cnt_nxt   = PHASE_LAST;
                        w_is_wr_nxt = 1'b1;
                        w_addr_nxt  = w_kb_map.addr;
                        w_wdata_nxt = bus.kb_data;
                    end else begin
                        w_kb_illegal = 1'b1;
                    end
                end else if (r_in_burst || r_pending) begin
                    w_burst_start = !r_in_burst;
                    w_state_nxt   = ST_ADDR_LOW;
                    w_cnt_nxt     = PHASE_LAST;
                    w_is_wr_nxt   = 1'b0;
                    w_addr_nxt    = w_rf_map.addr;
                    w_cur_idx_nxt = r_burst_idx;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR_LOW: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_ADDR_GAP;
                    w_cnt_nxt   = GAP_LAST;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_ADDR_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DATA_LOW;
                    w_cnt_nxt   = PHASE_LAST;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_DATA_LOW: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DATA_GAP;
                    w_cnt_nxt   = GAP_LAST;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_DATA_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_read_done = !r_is_wr;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Pin levels and pulses decoded from the next state so outputs are registered.
    always_comb begin
        w_cs_n     = STROBE_OFF;
        w_rd_n     = STROBE_OFF;
        w_wr_n     = STROBE_OFF;
        w_ad_sel   = 1'b0;
        w_ad_oe    = 1'b0;
        w_ad_out   = 8'h00;
        case (w_state_nxt)
            ST_ADDR_LOW: begin
                w_cs_n   = STROBE_ON;
                w_wr_n   = STROBE_ON;
                w_ad_oe  = 1'b1;
                w_ad_out = w_addr_nxt;
            end
            ST_ADDR_GAP: begin
                w_cs_n   = STROBE_ON;
                w_ad_oe  = 1'b1;
                w_ad_out = w_addr_nxt;
            end
            ST_DATA_LOW: begin
                w_cs_n   = STROBE_ON;
                w_ad_sel = 1'b1;
                if (w_is_wr_nxt) begin
                    w_wr_n   = STROBE_ON;
                    w_ad_oe  = 1'b1;
                    w_ad_out = w_wdata_nxt;
                end else begin
                    w_rd_n   = STROBE_ON;
                end
            end
            ST_DATA_GAP: begin
                w_cs_n   = STROBE_ON;
                w_ad_sel = 1'b1;
            end
            default: begin
                w_cs_n = STROBE_OFF;
            end
        endcase
        w_kb_ack    = ((w_state_nxt == ST_DATA_GAP) && (w_cnt_nxt == '0) && w_is_wr_nxt) || w_kb_illegal;
        w_rd_valid  = (w_state_nxt == ST_DATA_GAP) && (r_state == ST_DATA_LOW) && !w_is_wr_nxt;
        w_rd_sample = (r_state == ST_DATA_LOW) && (r_cnt == '0) && !r_is_wr;
    end

    // Transaction state, kb arming, refresh pending and burst progress.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_is_wr     <= 1'b0;
            r_addr      <= 8'h00;
            r_wdata     <= 8'h00;
            r_cur_idx   <= 4'd0;
            r_burst_idx <= 4'd0;
            r_kb_armed  <= 1'b1;
            r_pending   <= 1'b0;
            r_in_burst  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_is_wr   <= w_is_wr_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_cur_idx <= w_cur_idx_nxt;
            if (w_kb_accept) begin
                r_kb_armed <= 1'b0;
            end else if (!bus.kb_req) begin
                r_kb_armed <= 1'b1;
            end else begin
                r_kb_armed <= r_kb_armed;
            end
            if (w_tick) begin
                r_pending <= 1'b1;
            end else if (w_burst_start) begin
                r_pending <= 1'b0;
            end else begin
                r_pending <= r_pending;
            end
            if (w_burst_start) begin
                r_in_burst <= 1'b1;
            end else if (w_read_done && (r_cur_idx == LAST_IDX)) begin
                r_in_burst <= 1'b0;
            end else begin
                r_in_burst <= r_in_burst;
            end
            if (w_read_done) begin
                r_burst_idx <= (r_cur_idx == LAST_IDX) ? 4'd0 : (r_cur_idx + 4'd1);
            end else begin
                r_burst_idx <= r_burst_idx;
            end
        end
    end

    // Output registers; reset forces strobes inactive immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cs_n     <= STROBE_OFF;
            r_rd_n     <= STROBE_OFF;
            r_wr_n     <= STROBE_OFF;
            r_ad_sel   <= 1'b0;
            r_ad_oe    <= 1'b0;
            r_ad_out   <= 8'h00;
            r_kb_ack   <= 1'b0;
            r_kb_err   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_index <= 4'd0;
            r_rd_data  <= 8'h00;
        end else begin
            r_cs_n     <= w_cs_n;
            r_rd_n     <= w_rd_n;
            r_wr_n     <= w_wr_n;
            r_ad_sel   <= w_ad_sel;
            r_ad_oe    <= w_ad_oe;
            r_ad_out   <= w_ad_out;
            r_kb_ack   <= w_kb_ack;
            r_kb_err   <= w_kb_illegal;
            r_rd_valid <= w_rd_valid;
            if (w_rd_sample) begin
                r_rd_data  <= bus.rtc_ad_in;
                r_rd_index <= r_cur_idx;
            end else begin
                r_rd_data  <= r_rd_data;
                r_rd_index <= r_rd_index;
            end
        end
    end

    assign bus.rtc_cs_n   = r_cs_n;
    assign bus.rtc_rd_n   = r_rd_n;
    assign bus.rtc_wr_n   = r_wr_n;
    assign bus.rtc_ad_sel = r_ad_sel;
    assign bus.rtc_ad_oe  = r_ad_oe;
    assign bus.rtc_ad_out = r_ad_out;
    assign bus.kb_ack     = r_kb_ack;
    assign bus.kb_err     = r_kb_err;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_index   = r_rd_index;
    assign bus.rd_data    = r_rd_data;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed bench for rtc_bus_scheduler with T_PHASE=2, T_GAP=1, REFRESH_PERIOD=200.
module tb_rtc_bus_scheduler;

    logic CLK;
    logic RESET;
    int   total;
    int   bad;

    rtc_bus_scheduler_if bus_if ();

    rtc_bus_scheduler #(
        .T_PHASE        (2),
        .T_GAP          (1),
        .REFRESH_PERIOD (200)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RTC model: data read back is 0x10 + low nibble of the last address phase.
    logic [7:0] model_addr;
    int         ack_cnt;
    int         err_cnt;
    logic [7:0] rd_idx_q [$];
    logic [7:0] rd_dat_q [$];
    logic [7:0] order_q  [$];

    assign bus_if.rtc_ad_in = 8'h10 + {4'h0, model_addr[3:0]};

    initial begin
        model_addr = 8'h00;
        ack_cnt    = 0;
        err_cnt    = 0;
    end

    always @(negedge CLK) begin
        if (!bus_if.rtc_cs_n && !bus_if.rtc_ad_sel && bus_if.rtc_ad_oe) model_addr <= bus_if.rtc_ad_out;
        if (bus_if.kb_ack) ack_cnt <= ack_cnt + 1;
        if (bus_if.kb_err) err_cnt <= err_cnt + 1;
        if (bus_if.kb_ack && !bus_if.kb_err) order_q.push_back(8'hFF);
        if (bus_if.rd_valid) begin
            rd_idx_q.push_back({4'h0, bus_if.rd_index});
            rd_dat_q.push_back(bus_if.rd_data);
            order_q.push_back({4'h0, bus_if.rd_index});
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    localparam logic E_CS  [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic E_WR  [0:6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic E_SEL [0:6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic E_OE  [0:6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic E_ACK [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [7:0] E_OUT [0:6] = '{8'h23, 8'h23, 8'h23, 8'h45, 8'h45, 8'h00, 8'h00};
    localparam logic [7:0] E_RD  [0:8] = '{8'h11, 8'h12, 8'h13, 8'h16, 8'h15, 8'h14, 8'h11, 8'h12, 8'h13};
    localparam logic [7:0] E_ORD [0:9] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

    initial begin
        int n;
        int base;
        total           = 0;
        bad             = 0;
        RESET           = 1'b0;
        bus_if.kb_req   = 1'b0;
        bus_if.kb_index = 4'd0;
        bus_if.kb_data  = 8'h00;
        #2 RESET = 1'b1;
        repeat (3) step();

        chk("rst_cs_n",   bus_if.rtc_cs_n,   1);
        chk("rst_rd_n",   bus_if.rtc_rd_n,   1);
        chk("rst_wr_n",   bus_if.rtc_wr_n,   1);
        chk("rst_ad_sel", bus_if.rtc_ad_sel, 0);
        chk("rst_ad_out", bus_if.rtc_ad_out, 0);
        chk("rst_ad_oe",  bus_if.rtc_ad_oe,  0);
        chk("rst_kb_ack", bus_if.kb_ack,     0);
        chk("rst_kb_err", bus_if.kb_err,     0);
        chk("rst_rd_vld", bus_if.rd_valid,   0);
        chk("rst_rd_idx", bus_if.rd_index,   0);
        chk("rst_rd_dat", bus_if.rd_data,    0);
        RESET = 1'b0;
        step();

        // Single legal write, cycle by cycle.
        bus_if.kb_req   = 1'b1;
        bus_if.kb_index = 4'd2;
        bus_if.kb_data  = 8'h45;
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("wr_cs_n[%0d]", k),  bus_if.rtc_cs_n,   E_CS[k]);
            chk($sformatf("wr_wr_n[%0d]", k),  bus_if.rtc_wr_n,   E_WR[k]);
            chk($sformatf("wr_rd_n[%0d]", k),  bus_if.rtc_rd_n,   1);
            chk($sformatf("wr_sel[%0d]", k),   bus_if.rtc_ad_sel, E_SEL[k]);
            chk($sformatf("wr_oe[%0d]", k),    bus_if.rtc_ad_oe,  E_OE[k]);
            chk($sformatf("wr_ack[%0d]", k),   bus_if.kb_ack,     E_ACK[k]);
            chk($sformatf("wr_err[%0d]", k),   bus_if.kb_err,     0);
            if (E_OE[k]) chk($sformatf("wr_out[%0d]", k), bus_if.rtc_ad_out, E_OUT[k]);
        end
        bus_if.kb_req = 1'b0;
        step();

        // Illegal index: ack+err next cycle, no bus activity.
        bus_if.kb_req   = 1'b1;
        bus_if.kb_index = 4'd13;
        step();
        chk("ill_ack",  bus_if.kb_ack,   1);
        chk("ill_err",  bus_if.kb_err,   1);
        chk("ill_cs_n", bus_if.rtc_cs_n, 1);
        bus_if.kb_req = 1'b0;
        step();
        chk("ill_ack_end", bus_if.kb_ack,   0);
        chk("ill_cs_n2",   bus_if.rtc_cs_n, 1);

        // Level held high yields one write; a one-cycle low re-arms.
        base            = ack_cnt;
        bus_if.kb_index = 4'd0;
        bus_if.kb_data  = 8'h30;
        bus_if.kb_req   = 1'b1;
        repeat (50) step();
        chk("hold_one_ack", ack_cnt - base, 1);
        chk("hold_no_err",  err_cnt,        1);
        bus_if.kb_req = 1'b0;
        step();
        bus_if.kb_req = 1'b1;
        n = 0;
        while (ack_cnt - base < 2 && n < 20) begin step(); n++; end
        chk("rearm_second_ack", ack_cnt - base, 2);
        bus_if.kb_req = 1'b0;
        step();

        // First refresh burst.
        n = 0;
        while (rd_idx_q.size() < 9 && n < 400) begin step(); n++; end
        chk("burst_count", rd_idx_q.size(), 9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("burst_idx[%0d]", i),  rd_idx_q[i], i);
            chk($sformatf("burst_data[%0d]", i), rd_dat_q[i], E_RD[i]);
        end

        // kb write injected while index 3 is being read.
        base = order_q.size();
        n = 0;
        while (!(!bus_if.rtc_cs_n && !bus_if.rtc_ad_sel && bus_if.rtc_ad_out == 8'h26) && n < 300) begin
            step(); n++;
        end
        chk("seen_read3", n < 300, 1);
        bus_if.kb_index = 4'd5;
        bus_if.kb_data  = 8'h07;
        bus_if.kb_req   = 1'b1;
        n = 0;
        while (order_q.size() - base < 10 && n < 200) begin step(); n++; end
        chk("inter_count", order_q.size() - base, 10);
        for (int i = 0; i < 10; i++) chk($sformatf("inter_order[%0d]", i), order_q[base + i], E_ORD[i]);
        bus_if.kb_req = 1'b0;
        step();

        // Reset in the data phase of a write.
        bus_if.kb_index = 4'd1;
        bus_if.kb_data  = 8'h59;
        bus_if.kb_req   = 1'b1;
        n = 0;
        while (!(bus_if.rtc_ad_sel && !bus_if.rtc_wr_n) && n < 50) begin step(); n++; end
        chk("seen_wr_data", n < 50, 1);
        bus_if.kb_req = 1'b0;
        base  = ack_cnt;
        RESET = 1'b1;
        #1;
        chk("arst_cs_n",  bus_if.rtc_cs_n,   1);
        chk("arst_wr_n",  bus_if.rtc_wr_n,   1);
        chk("arst_rd_n",  bus_if.rtc_rd_n,   1);
        chk("arst_ad_oe", bus_if.rtc_ad_oe,  0);
        chk("arst_sel",   bus_if.rtc_ad_sel, 0);
        step();
        step();
        RESET = 1'b0;
        repeat (20) step();
        chk("arst_no_ack", ack_cnt - base, 0);
        base = rd_idx_q.size();
        n = 0;
        while (rd_idx_q.size() <= base && n < 400) begin step(); n++; end
        chk("post_rst_burst", rd_idx_q.size() > base, 1);
        chk("post_rst_idx0",  rd_idx_q[base], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
